div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have start, input, 1, request a division; sampled only while ready=1.
REQ-004 SHALL have divident, input, 16, signed two's-complement dividend; sampled on the accepting edge.
REQ-005 SHALL have divisor, input, 16, signed two's-complement divisor; sampled on the accepting edge.
REQ-006 SHALL have ready, output, 1, high when state=IDLE.
REQ-007 SHALL have busy, output, 1, high in ITER and FIX.
REQ-008 SHALL have done, output, 1, one-cycle result-valid pulse.
REQ-009 SHALL have quotient, output, 16, signed result, registered.
REQ-010 SHALL have remainder, output, 16, signed result, registered.
REQ-011 SHALL have div_by_zero, output, 1, status of the last completed operation.
REQ-012 SHALL have overflow, output, 1, status of the last completed operation.

Function
REQ-013 SHALL implement FSM states IDLE, ITER, FIX, DONE.
REQ-014 SHALL accept on the edge where state=IDLE and start=1.
- That edge latches operand signs and absolute values (|-32768| held as 17-bit 32768).
- That edge clears the 17-bit partial remainder and sets the step counter to 15.
REQ-015 Accept edge with divisor!=0 SHALL go to ITER.
REQ-016 Accept edge with divisor=0 SHALL go directly to DONE.
- quotient=16'hFFFF, remainder=divident, div_by_zero=1, overflow=0.
REQ-017 ITER SHALL perform one unsigned non-restoring step per cycle.
- Partial remainder >=0: shift left with next dividend bit, subtract |divisor|.
- Otherwise: shift left with next dividend bit, add |divisor|.
- Quotient bit = NOT sign of the new partial remainder.
REQ-018 ITER SHALL decrement the counter each cycle and go to FIX on the edge where the counter is 0 (exactly 16 ITER cycles).
REQ-019 FIX SHALL apply the sign correction and go to DONE.
- Add |divisor| to the partial remainder if it is negative.
- Negate quotient if the operand signs differ; negate remainder if divident<0.
- Quotient truncates toward zero; remainder takes the sign of divident (matches Verilog / and %).
REQ-020 FIX with divident=-32768 and divisor=-1 SHALL give quotient=16'h8000, remainder=0, overflow=1.
REQ-021 FIX in all other non-zero-divisor cases SHALL set overflow=0 and div_by_zero=0.
REQ-022 DONE SHALL assert done=1 for exactly one cycle and return to IDLE unconditionally; start in DONE is ignored.
REQ-023 Latency SHALL be fixed.
- Accept on edge k gives done=1 in the cycle after edge k+17 (non-zero divisor).
- Accept on edge k gives done=1 in the cycle after edge k (zero divisor).
REQ-024 start while busy=1 or in DONE SHALL be ignored, with no queuing.
REQ-025 Operand input changes after the accept edge SHALL NOT affect the in-flight result.
REQ-026 quotient, remainder, div_by_zero and overflow SHALL update only on entry to DONE and hold until the next completion.
REQ-027 ready, busy and done SHALL be mutually exclusive.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE from any state, aborting any in-flight operation without a done pulse.
REQ-029 Reset SHALL clear quotient, remainder, div_by_zero, overflow, done, busy and the internal counter/partial remainder to 0, and set ready=1 on the following cycle.
REQ-030 rst SHALL take priority over start on the same edge.

Verification
REQ-031 Scenario: divident=100, divisor=7, start for 1 cycle -> done 17 edges after accept; quotient=14, remainder=2, flags 0.
REQ-032 Scenario: sign cases -> (-100,7) gives -14,-2; (100,-7) gives -14,2; (-100,-7) gives 14,-2; (-200,200) gives -1,0.
REQ-033 Scenario: (-32768,-1) -> quotient=-32768, remainder=0, overflow=1; (-32768,1) -> quotient=-32768, remainder=0, overflow=0.
REQ-034 Scenario: (5,0) -> done in the cycle after accept; quotient=16'hFFFF, remainder=5, div_by_zero=1.
REQ-035 Scenario: start held high continuously with new operands each cycle -> operations back-to-back every 19 cycles.
- Each result matches only the operands sampled on its accept edge.
REQ-036 Scenario: rst=1 on the 8th ITER cycle -> next cycle ready=1, all outputs 0, no done.
- A new start then completes normally (200/-3 gives -66,2).
- Bench also randomizes 1000 operand pairs in [-200,200] plus the corner values against the / and % reference.

Source files
------------

// File: rtl/div_sequencer_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// Latency: none, this is wiring only.
// Backpressure: the requester holds start until ready is seen; results are valid while done is high.
interface div_sequencer_if;
  logic        start;
  logic [15:0] divident;
  logic [15:0] divisor;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  modport master (
    output start, divident, divisor,
    input  ready, busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, divident, divisor,
    output ready, busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div_sequencer.sv
// 16-bit signed divider: magnitude non-restoring core plus sign fix-up.
// Latency: done 18 cycles after accept (1 cycle for a zero divisor), one op per 19 cycles.
// Backpressure: start is only taken while ready; requests in ITER/FIX/DONE are dropped, not queued.
module div_sequencer (
  input logic           clk,
  input logic           rst,
  div_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [16:0] pr;        // signed partial remainder
  logic [15:0] qsh;       // dividend magnitude shifting out, quotient bits shifting in
  logic [16:0] dsr;       // divisor magnitude; 32768 needs the 17th bit
  logic        neg_a;
  logic        neg_b;
  logic        ovf_case;

  logic [15:0] quo_q;
  logic [15:0] rem_q;
  logic        dz_q;
  logic        ov_q;

  logic [15:0] a_mag;
  logic [15:0] b_mag;
  logic [16:0] pr_shift;
  logic [16:0] pr_next;
  logic [15:0] rem_mag;
  logic [15:0] q_fix;
  logic [15:0] r_fix;
  logic        accept;

  assign accept = (state == IDLE) && bus.start;

  // Operand magnitudes; -32768 maps onto 16'h8000 which is its correct unsigned magnitude.
  assign a_mag = bus.divident[15] ? (~bus.divident + 16'd1) : bus.divident;
  assign b_mag = bus.divisor[15]  ? (~bus.divisor  + 16'd1) : bus.divisor;

  // One non-restoring step: shift in the next dividend bit, then subtract or add by remainder sign.
  assign pr_shift = {pr[15:0], qsh[15]};
  assign pr_next  = pr[16] ? (pr_shift + dsr) : (pr_shift - dsr);

  // Final remainder correction; the true value is below 32768 so 16 bits hold it exactly.
  assign rem_mag = pr[16] ? (pr[15:0] + dsr[15:0]) : pr[15:0];
  assign q_fix   = (neg_a ^ neg_b) ? (~qsh + 16'd1) : qsh;
  assign r_fix   = neg_a ? (~rem_mag + 16'd1) : rem_mag;

  // Control FSM and iterative datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      pr       <= 17'd0;
      qsh      <= 16'd0;
      dsr      <= 17'd0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      ovf_case <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_a    <= bus.divident[15];
            neg_b    <= bus.divisor[15];
            qsh      <= a_mag;
            dsr      <= {1'b0, b_mag};
            pr       <= 17'd0;
            cnt      <= 4'd15;
            ovf_case <= (bus.divident == 16'h8000) && (bus.divisor == 16'hFFFF);
            state    <= (bus.divisor == 16'd0) ? DONE : ITER;
          end
        end
        ITER: begin
          pr  <= pr_next;
          qsh <= {qsh[14:0], ~pr_next[16]};
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            state <= FIX;
          end
        end
        FIX: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Result registers load only when entering DONE and otherwise hold the last completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= 16'd0;
      rem_q <= 16'd0;
      dz_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else if (accept && (bus.divisor == 16'd0)) begin
      quo_q <= 16'hFFFF;
      rem_q <= bus.divident;
      dz_q  <= 1'b1;
      ov_q  <= 1'b0;
    end else if (state == FIX) begin
      quo_q <= q_fix;
      rem_q <= r_fix;
      dz_q  <= 1'b0;
      ov_q  <= ovf_case;
    end
  end

  assign bus.ready       = (state == IDLE);
  assign bus.busy        = (state == ITER) || (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ov_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomized checks of div_sequencer against Verilog / and % semantics.
// Latency: checks done 17 edges after accept (same cycle for zero divisor).
// Backpressure: exercises start held high, start while busy, and reset mid-operation.
module tb_div_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_sequencer_if dif();

  div_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int checks = 0;
  int errors = 0;

  int ca [8] = '{32767, -32768, -32768, 32767, 0, -1, 7, -32768};
  int cb [8] = '{-32768, -32768, 32767, 1, 5, 200, -32768, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int a, input int b, output logic [15:0] q,
                                output logic [15:0] r, output logic dz, output logic ov);
    if (b == 0) begin
      q  = 16'hFFFF;
      r  = 16'(a);
      dz = 1'b1;
      ov = 1'b0;
    end else begin
      q  = 16'(a / b);
      r  = 16'(a % b);
      dz = 1'b0;
      ov = (a == -32768) && (b == -1);
    end
  endfunction

  // Called just after a negedge; returns one negedge after the done cycle.
  task automatic run_op(input int a, input int b, output logic [15:0] q, output logic [15:0] r,
                        output logic dz, output logic ov, output int lat);
    int w;
    w = 0;
    while (dif.ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    dif.divident = 16'(a);
    dif.divisor  = 16'(b);
    dif.start    = 1'b1;
    @(posedge clk);
    #1;
    dif.start    = 1'b0;
    dif.divident = 16'h5A5A;
    dif.divisor  = 16'h0003;
    @(negedge clk);
    lat = 0;
    while (dif.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q  = dif.quotient;
    r  = dif.remainder;
    dz = dif.div_by_zero;
    ov = dif.overflow;
    @(negedge clk);
  endtask

  task automatic check_op(input string tag, input int a, input int b);
    logic [15:0] q, r, eq, er;
    logic        dz, ov, edz, eov;
    int          lat;
    model(a, b, eq, er, edz, eov);
    run_op(a, b, q, r, dz, ov, lat);
    chk({tag, "_quo"}, q, eq);
    chk({tag, "_rem"}, r, er);
    chk({tag, "_dz"},  dz, edz);
    chk({tag, "_ovf"}, ov, eov);
    chk({tag, "_lat"}, lat, (b == 0) ? 0 : 17);
  endtask

  initial begin
    int          nd, last_c, nacc, nres, pa, pb, ra, rb;
    logic [15:0] pq, prr;
    logic        pdz, pov, rdy;

    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.divident = 16'd0;
    dif.divisor  = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_ready", dif.ready, 1);
    chk("rst_busy",  dif.busy, 0);
    chk("rst_done",  dif.done, 0);
    chk("rst_outs",  {dif.quotient, dif.remainder}, 0);
    chk("rst_flags", {dif.div_by_zero, dif.overflow}, 0);

    // Basic and sign cases with hand-derived results.
    check_op("p100_7", 100, 7);
    chk("p100_7_hand", {dif.quotient, dif.remainder}, {16'd14, 16'd2});
    chk("done_pulse", dif.done, 0);
    chk("idle_after", dif.ready, 1);
    check_op("m100_7", -100, 7);
    chk("m100_7_hand", {dif.quotient, dif.remainder}, {16'hFFF2, 16'hFFFE});
    check_op("p100_m7", 100, -7);
    chk("p100_m7_hand", {dif.quotient, dif.remainder}, {16'hFFF2, 16'd2});
    check_op("m100_m7", -100, -7);
    chk("m100_m7_hand", {dif.quotient, dif.remainder}, {16'd14, 16'hFFFE});
    check_op("m200_200", -200, 200);
    chk("m200_200_hand", {dif.quotient, dif.remainder}, {16'hFFFF, 16'd0});

    // Overflow and most-negative dividend.
    check_op("ovf", -32768, -1);
    chk("ovf_hand", {dif.quotient, dif.remainder, 1'b0, dif.overflow}, {16'h8000, 16'd0, 2'b01});
    check_op("min_div1", -32768, 1);
    chk("min_div1_hand", {dif.quotient, dif.overflow}, {16'h8000, 1'b0});

    // Divide by zero.
    check_op("dz", 5, 0);
    chk("dz_hand", {dif.quotient, dif.remainder, 1'b0, dif.div_by_zero}, {16'hFFFF, 16'd5, 2'b01});

    // Reset on the 8th ITER cycle; results held from the zero-divide until then.
    dif.divident = 16'd1000;
    dif.divisor  = 16'd3;
    dif.start    = 1'b1;
    @(posedge clk);
    #1 dif.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid_busy",  dif.busy, 1);
    chk("mid_start_ignored_ready", dif.ready, 0);
    chk("hold_quo",  dif.quotient, 16'hFFFF);
    chk("hold_dz",   dif.div_by_zero, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", dif.ready, 1);
    chk("abort_busy",  dif.busy, 0);
    chk("abort_done",  dif.done, 0);
    chk("abort_outs",  {dif.quotient, dif.remainder, dif.div_by_zero, dif.overflow}, 0);
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (dif.done === 1'b1) nd++;
    end
    chk("abort_no_done", nd, 0);
    check_op("after_abort", 200, -3);
    chk("after_abort_hand", {dif.quotient, dif.remainder}, {16'hFFBE, 16'd2});

    // Start held high with operands changing every cycle.
    last_c = -1;
    nacc   = 0;
    nres   = 0;
    pq     = 16'd0;
    prr    = 16'd0;
    for (int c = 0; c < 77; c++) begin
      if (dif.done === 1'b1) begin
        chk("b2b_quo", dif.quotient, pq);
        chk("b2b_rem", dif.remainder, prr);
        nres++;
      end
      chk("b2b_excl", $countones({dif.ready, dif.busy, dif.done}), 1);
      pa = ((c * 523) % 4001) - 2000;
      pb = (c % 7) - 3;
      if (pb == 0) pb = 5;
      dif.divident = 16'(pa);
      dif.divisor  = 16'(pb);
      dif.start    = (c < 58);
      rdy          = dif.ready;
      @(posedge clk);
      if (rdy && c < 58) begin
        if (last_c >= 0) chk("b2b_gap", c - last_c, 19);
        last_c = c;
        nacc++;
        model(pa, pb, pq, prr, pdz, pov);
      end
      @(negedge clk);
    end
    dif.start = 1'b0;
    chk("b2b_accepts", nacc, 4);
    chk("b2b_results", nres, 4);

    // Corner operand pairs.
    for (int i = 0; i < 8; i++) check_op("corner", ca[i], cb[i]);

    // Random operands in [-200, 200], zero divisor included.
    for (int i = 0; i < 1000; i++) begin
      ra = int'($urandom_range(400)) - 200;
      rb = int'($urandom_range(400)) - 200;
      check_op("rand", ra, rb);
    end

    // Reset wins over start on the same edge.
    dif.divident = 16'd9;
    dif.divisor  = 16'd2;
    dif.start    = 1'b1;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    dif.start = 1'b0;
    @(negedge clk);
    chk("rst_prio_ready", dif.ready, 1);
    chk("rst_prio_busy",  dif.busy, 0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (dif.done === 1'b1) nd++;
    end
    chk("rst_prio_no_done", nd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
